// File: rtl/mips_alu_pkg.sv
// Shared ALU select constants, mul/div op codes and sequencer state encoding
// for the MIPS execute-stage datapath.
package mips_alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic MD_MULTU = 1'b0;
   localparam logic MD_DIVU  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_STEP = 2'd1,
      ST_DIV_STEP = 2'd2,
      ST_DONE     = 2'd3
   } md_state_e;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the shared ALU for
// one add or subtract per iteration and produces the HI/LO result pair.
module alu_muldiv_sequencer
   import mips_alu_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op,
   input  logic [N-1:0] src_a,
   input  logic [N-1:0] src_b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         div_by_zero,
   output logic [3:0]   alu_sel,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_out,
   input  logic         alu_cout
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   md_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   // rh: acc / rem, rl: mlo / quo, rb: mcand / dvs
   logic [N-1:0]   rh_q, rh_d;
   logic [N-1:0]   rl_q, rl_d;
   logic [N-1:0]   rb_q, rb_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic           dbz_q, dbz_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [N-1:0]   div_sh;
   logic           div_msb;

   assign div_sh  = {rh_q[N-2:0], rl_q[N-1]};
   assign div_msb = rh_q[N-1];

   // Kept apart from the next-state logic so the external ALU path
   // (alu_a/alu_b -> alu_out) never looks like a loop through one block.
   always_comb begin
      alu_sel = ALU_ADD;
      alu_a   = '0;
      alu_b   = '0;
      case (state_q)
         ST_MUL_STEP: begin
            alu_sel = ALU_ADD;
            alu_a   = rh_q;
            alu_b   = rl_q[0] ? rb_q : '0;
         end
         ST_DIV_STEP: begin
            alu_sel = ALU_SUB;
            alu_a   = div_sh;
            alu_b   = rb_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rh_d    = rh_q;
      rl_d    = rl_q;
      rb_d    = rb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rh_d  = '0;
               rl_d  = src_a;
               rb_d  = src_b;
               cnt_d = CW'(N - 1);
               dbz_d = 1'b0;
               if (op == MD_MULTU) begin
                  state_d = ST_MUL_STEP;
               end else if (src_b == '0) begin
                  state_d = ST_DONE;
                  hi_d    = src_a;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = ST_DIV_STEP;
               end
            end
         end
         ST_MUL_STEP: begin
            {rh_d, rl_d} = {alu_cout, alu_out, rl_q[N-1:1]};
            cnt_d        = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               hi_d    = rh_d;
               lo_d    = rl_d;
            end
         end
         ST_DIV_STEP: begin
            // msb set means the shifted remainder is >= 2^N, so it always fits the divisor
            if (div_msb | alu_cout) begin
               rh_d = alu_out;
               rl_d = {rl_q[N-2:0], 1'b1};
            end else begin
               rh_d = div_sh;
               rl_d = {rl_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               hi_d    = rh_d;
               lo_d    = rl_d;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rh_q    <= '0;
         rl_q    <= '0;
         rb_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rh_q    <= rh_d;
         rl_q    <= rl_d;
         rb_q    <= rb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: behavioural ALU on the alu_* ports, a
// cycle-level result model checked every cycle, plus hand-computed vectors.
module tb_alu_muldiv_sequencer;
   import mips_alu_pkg::*;

   localparam int unsigned N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [N-1:0] src_a = '0;
   logic [N-1:0] src_b = '0;
   logic         busy, done, div_by_zero;
   logic [N-1:0] hi, lo;
   logic [3:0]   alu_sel;
   logic [N-1:0] alu_a, alu_b, alu_out;
   logic         alu_cout;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   alu_muldiv_sequencer #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero),
      .alu_sel     (alu_sel),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_out     (alu_out),
      .alu_cout    (alu_cout)
   );

   always #5 clk = ~clk;

   // Shared ALU: ADD gives carry out, SUB gives cout=1 when no borrow.
   logic [N:0] alu_sum;
   always_comb begin
      alu_sum  = '0;
      alu_out  = '0;
      alu_cout = 1'b0;
      if (alu_sel == ALU_SUB) begin
         alu_out  = alu_a - alu_b;
         alu_cout = (alu_a >= alu_b);
      end else begin
         alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
         alu_out  = alu_sum[N-1:0];
         alu_cout = alu_sum[N];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Result model: outputs the block must show in the cycle after each edge.
   int           m_cnt = 0;
   bit           m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
   logic [N-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_dbz  = 1'b0;
      end else begin
         if (!m_busy && start) begin
            if (op == MD_DIVU && src_b == '0) begin
               p_hi = src_a; p_lo = '1; p_dbz = 1'b1; m_cnt = 1;
            end else if (op == MD_MULTU) begin
               {p_hi, p_lo} = 64'(src_a) * 64'(src_b); p_dbz = 1'b0; m_cnt = N + 1;
            end else begin
               p_hi = src_a % src_b; p_lo = src_a / src_b; p_dbz = 1'b0; m_cnt = N + 1;
            end
            m_dbz = 1'b0;
         end
         if (m_cnt > 0) begin
            m_cnt--;
            m_busy = 1'b1;
            m_done = (m_cnt == 0);
            if (m_done) begin
               m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
            end
         end else begin
            m_busy = 1'b0;
            m_done = 1'b0;
         end
         #1;
         if (rst_n) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            if (!m_busy || m_done) begin
               check("alu_idle_drive", {28'd0, alu_sel, alu_a | alu_b}, 64'd0);
            end
         end
      end
   end

   task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int p1, input int p2, output int lat);
      int k;
      int guard;
      bit got;
      @(negedge clk);
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b1; op = o; src_a = a; src_b = b;
      k = 0; got = 1'b0;
      while (!got && k < 60) begin
         @(posedge clk); #1;
         k++;
         start = (k == p1 || k == p2);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      lat = got ? k : -1;
      if (!got) check("done_timeout", 64'd0, 64'd1);
   endtask

   logic [N-1:0] specials [4];
   logic [N-1:0] ra, rb;
   logic         rop;
   int           lat, k;

   initial begin
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h0000_0001;
      specials[2] = 32'h8000_0000;
      specials[3] = 32'hFFFF_FFFF;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy_done", {62'd0, busy, done}, 64'd0);
      check("rst_hi_lo", {hi, lo}, 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      check("rst_alu", {28'd0, alu_sel, alu_a | alu_b}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, lat);
      check("mul_ff_lat", 64'(lat), 64'd33);
      check("mul_ff_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      run_op(MD_DIVU, 32'd100, 32'd7, -1, -1, lat);
      check("div_100_7", {hi, lo}, {32'd2, 32'd14});
      check("div_100_7_dbz", 64'(div_by_zero), 64'd0);

      run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, -1, -1, lat);
      check("div_msb_path", {hi, lo}, {32'h7FFF_FFFF, 32'd1});

      run_op(MD_DIVU, 32'h0000_1234, 32'd0, -1, -1, lat);
      check("dbz_lat", 64'(lat), 64'd1);
      check("dbz_flag", 64'(div_by_zero), 64'd1);
      check("dbz_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});

      run_op(MD_MULTU, 32'd3, 32'd5, -1, -1, lat);
      check("mul_3_5", {hi, lo}, 64'd15);
      check("mul_3_5_dbz_clr", 64'(div_by_zero), 64'd0);

      run_op(MD_MULTU, 32'h1234_5678, 32'd9, 5, 20, lat);
      check("ignored_start_lat", 64'(lat), 64'd33);
      check("ignored_start_res", {hi, lo}, 64'h0000_0000_A3D7_0A38);

      // start held from the DONE cycle: first edge ignored, second accepted
      start = 1'b1; op = MD_MULTU; src_a = 32'd6; src_b = 32'd7;
      @(posedge clk); #1;
      check("done_cycle_start_ignored", 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("next_cycle_start_taken", 64'(busy), 64'd1);
      k = 1;
      while (!done && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      check("retry_lat", 64'(k), 64'd33);
      check("retry_res", {hi, lo}, 64'd42);

      @(negedge clk);
      start = 1'b1; op = MD_DIVU; src_a = 32'd1000; src_b = 32'd10;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_busy_done", {62'd0, busy, done}, 64'd0);
      check("async_rst_hi_lo", {hi, lo}, 64'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check("no_done_in_rst", 64'(done), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MD_DIVU, 32'd9, 32'd3, -1, -1, lat);
      check("div_9_3", {hi, lo}, {32'd0, 32'd3});
      check("div_9_3_lat", 64'(lat), 64'd33);

      for (int i = 0; i < 2000; i++) begin
         ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         rop = 1'($urandom_range(0, 1));
         run_op(rop, ra, rb, -1, -1, lat);
         check("rand_lat", 64'(lat), (rop == MD_DIVU && rb == '0) ? 64'd1 : 64'd33);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
